// File: rtl/div_272x16_pkg.sv
// Shared constants and state encoding for the 272/16 restoring divider.
package ecdsa_div_pkg;

  localparam int unsigned DIV_DW    = 16;
  localparam int unsigned DIV_QW    = 256;
  localparam int unsigned DIV_PW    = DIV_DW + DIV_QW;
  localparam int unsigned DIV_CNT_W = 9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_272x16_if.sv
// Request/result bundle of the divider: requester drives start/a/p, divider returns results and flags.
interface div_272x16_if
  import ecdsa_div_pkg::*;
#(
  parameter int unsigned DW = DIV_DW,
  parameter int unsigned QW = DIV_QW
);
  localparam int unsigned PW = DW + QW;

  logic          start;
  logic [DW-1:0] a;
  logic [PW-1:0] p;
  logic [QW-1:0] q;
  logic [DW-1:0] r;
  logic          busy;
  logic          done;
  logic          div_zero;
  logic          overflow;

  modport master (
    output start, a, p,
    input  q, r, busy, done, div_zero, overflow
  );

  modport slave (
    input  start, a, p,
    output q, r, busy, done, div_zero, overflow
  );
endinterface

// File: rtl/div_272x16_step.sv
// One combinational restoring-division step: shift in a dividend bit, conditionally subtract the divisor.
module div_step #(
  parameter int unsigned DW = 16
) (
  input  logic [DW-1:0] rem,
  input  logic          bit_in,
  input  logic [DW-1:0] a,
  output logic [DW-1:0] rem_next,
  output logic          q_bit
);
  logic [DW:0] t;

  assign t     = {rem, bit_in};
  assign q_bit = (t >= {1'b0, a});
  // When subtracting, the true difference is below a, so the low DW bits are exact.
  assign rem_next = q_bit ? (t[DW-1:0] - a) : t[DW-1:0];
endmodule

// File: rtl/div_272x16.sv
// Sequential restoring divider, 272-bit dividend / 16-bit divisor -> 256-bit quotient + 16-bit remainder.
// Define DIV_RADIX4_EN to chain two restoring steps per clock (136-edge RUN instead of 272).
module div_272x16
  import ecdsa_div_pkg::*;
#(
  parameter int unsigned DW = DIV_DW,
  parameter int unsigned QW = DIV_QW
) (
  input  logic       clk,
  input  logic       reset,
  div_272x16_if.slave bus
);
  localparam int unsigned PW = DW + QW;
  localparam int unsigned CW = $clog2(PW);

  div_state_t    state, state_nx;
  logic [DW-1:0] a_reg;
  logic [DW-1:0] rem;
  logic [PW-1:0] sr;
  logic [CW-1:0] count;
  logic [QW-1:0] q_reg;
  logic [DW-1:0] r_reg;
  logic          dz_reg;
  logic          ov_reg;

  logic [PW-1:0] sr_nx;
  logic [DW-1:0] rem_nx;
  logic          last;

`ifdef DIV_RADIX4_EN
  localparam int unsigned STEPS = 2;
  logic [DW-1:0] rem_mid;
  logic          qb_hi;
  logic          qb_lo;

  div_step #(.DW(DW)) u_step_hi (
    .rem      (rem),
    .bit_in   (sr[PW-1]),
    .a        (a_reg),
    .rem_next (rem_mid),
    .q_bit    (qb_hi)
  );

  div_step #(.DW(DW)) u_step_lo (
    .rem      (rem_mid),
    .bit_in   (sr[PW-2]),
    .a        (a_reg),
    .rem_next (rem_nx),
    .q_bit    (qb_lo)
  );

  assign sr_nx = {sr[PW-3:0], qb_hi, qb_lo};
`else
  localparam int unsigned STEPS = 1;
  logic qb;

  div_step #(.DW(DW)) u_step (
    .rem      (rem),
    .bit_in   (sr[PW-1]),
    .a        (a_reg),
    .rem_next (rem_nx),
    .q_bit    (qb)
  );

  assign sr_nx = {sr[PW-2:0], qb};
`endif

  assign last = (count == CW'(PW - STEPS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nx = (bus.a == '0) ? DONE : RUN;
      RUN:        if (last)      state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  // Dividend and quotient share one shift register: dividend bits leave the top as quotient bits enter the bottom.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg  <= '0;
      rem    <= '0;
      sr     <= '0;
      count  <= '0;
      q_reg  <= '0;
      r_reg  <= '0;
      dz_reg <= 1'b0;
      ov_reg <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a_reg  <= bus.a;
            sr     <= bus.p;
            rem    <= '0;
            count  <= '0;
            q_reg  <= '0;
            r_reg  <= '0;
            dz_reg <= (bus.a == '0);
            ov_reg <= (bus.a != '0) && (bus.p[PW-1:QW] >= bus.a);
          end
        end
        RUN: begin
          sr    <= sr_nx;
          rem   <= rem_nx;
          count <= count + CW'(STEPS);
          if (last) begin
            q_reg <= sr_nx[QW-1:0];
            r_reg <= rem_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.q        = q_reg;
  assign bus.r        = r_reg;
  assign bus.div_zero = dz_reg;
  assign bus.overflow = ov_reg;
  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
endmodule

// File: tb/tb_div_272x16.sv
// Randomised scoreboard bench for div_272x16 against an arithmetic division reference.
module tb_div_272x16;
  import ecdsa_div_pkg::*;

  localparam int unsigned DW = DIV_DW;
  localparam int unsigned QW = DIV_QW;
  localparam int unsigned PW = DIV_PW;
`ifdef DIV_RADIX4_EN
  localparam int unsigned RUN_EDGES = PW / 2;
`else
  localparam int unsigned RUN_EDGES = PW;
`endif

  typedef struct {
    logic [QW-1:0] q;
    logic [DW-1:0] r;
    logic          dz;
    logic          ov;
    int unsigned   lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  div_272x16_if #(.DW(DW), .QW(QW)) bus ();

  div_272x16 #(.DW(DW), .QW(QW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int unsigned cap_cyc = 0;
  logic        waiting = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [DW-1:0] a, input logic [PW-1:0] p);
    exp_t          e;
    logic [PW-1:0] full;
    logic [PW-1:0] md;
    if (a == '0) begin
      e.q = '0; e.r = '0; e.dz = 1'b1; e.ov = 1'b0; e.lat = 0;
    end else begin
      full = p / {{QW{1'b0}}, a};
      md   = p % {{QW{1'b0}}, a};
      e.q   = full[QW-1:0];
      e.r   = md[DW-1:0];
      e.dz  = 1'b0;
      e.ov  = ((full >> QW) != '0);
      e.lat = RUN_EDGES;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (waiting && bus.done) begin
      exp_t e;
      waiting = 1'b0;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard: result with no pending expectation");
      end else begin
        e = sb.pop_front();
        chk("q", PW'(bus.q), PW'(e.q));
        chk("r", PW'(bus.r), PW'(e.r));
        chk("div_zero", PW'(bus.div_zero), PW'(e.dz));
        chk("overflow", PW'(bus.overflow), PW'(e.ov));
        chk("busy_at_done", PW'(bus.busy), '0);
        chk("latency", PW'(cyc - cap_cyc), PW'(e.lat));
      end
    end
  end

  function automatic logic [PW-1:0] rand_p();
    logic [PW-1:0] v = '0;
    for (int unsigned i = 0; i < 9; i++) v = {v[PW-33:0], 32'($urandom)};
    return v;
  endfunction

  task automatic issue(input logic [DW-1:0] a, input logic [PW-1:0] p, input bit mid_start);
    logic seen_busy = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.p     = p;
    sb.push_back(model(a, p));
    @(posedge clk);
    #1;
    cap_cyc   = cyc;
    waiting   = 1'b1;
    bus.start = 1'b0;
    bus.a     = 16'($urandom);
    bus.p     = rand_p();
    if (mid_start) begin
      repeat (40) @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 16'd5;
      bus.p     = rand_p();
      @(negedge clk);
      bus.start = 1'b0;
    end
    for (int unsigned i = 0; i < 400 && waiting; i++) begin
      @(negedge clk);
      if (bus.busy) seen_busy = 1'b1;
    end
    if (waiting) begin
      checks++;
      failures++;
      $display("FAIL timeout: done not seen a=%h", a);
      waiting = 1'b0;
      if (sb.size() != 0) void'(sb.pop_front());
    end
    if (a == '0) chk("zero_busy", PW'(seen_busy), '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] p_big;
    logic [PW-1:0] ones;
    logic [DW-1:0] ra;
    logic [PW-1:0] rp;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.p     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", PW'(bus.q), '0);
    chk("rst_r", PW'(bus.r), '0);
    chk("rst_busy", PW'(bus.busy), '0);
    chk("rst_done", PW'(bus.done), '0);
    chk("rst_div_zero", PW'(bus.div_zero), '0);
    chk("rst_overflow", PW'(bus.overflow), '0);
    @(negedge clk);
    reset = 1'b1;

    ones  = {{DW{1'b0}}, {QW{1'b1}}};
    p_big = ones * PW'(16'hFFFF) + PW'(16'hFFFE);
    issue(16'd3, PW'(10), 1'b0);
    issue(16'hFFFF, p_big, 1'b0);
    issue(16'h0000, rand_p(), 1'b0);
    issue(16'h0001, PW'(1) << (PW - 1), 1'b0);
    issue(16'hFFFF, p_big, 1'b1);

    // Abort a running operation with reset; outputs must clear without waiting for a clock.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h1234;
    bus.p     = rand_p();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_q", PW'(bus.q), '0);
    chk("rst_mid_r", PW'(bus.r), '0);
    chk("rst_mid_busy", PW'(bus.busy), '0);
    chk("rst_mid_done", PW'(bus.done), '0);
    chk("rst_mid_flags", PW'({bus.div_zero, bus.overflow}), '0);
    @(negedge clk);
    reset = 1'b1;
    issue(16'd7, PW'(50), 1'b0);

    for (int unsigned n = 0; n < 14; n++) begin
      ra = (n % 7 == 6) ? 16'h0000 : 16'($urandom_range(1, 65535));
      rp = rand_p();
      if (ra != '0 && (n % 2 == 0)) rp[PW-1:QW] = 16'($urandom_range(0, int'(ra) - 1));
      issue(ra, rp, 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
